ccff_chain_loader: RTL and testbench

- Upstream feeder for a tile's configuration-chain flip-flops: the per-mux select memories chained head to tail.
- Accepts bitstream words over a valid/ready handshake and serializes them onto ccff_head.
- Drives config_enable so that exactly CHAIN_LEN bits are shifted in per load.
- Sits between the fabric-level bitstream source and the ccff_head/ccff_tail pins of one logical tile, for example a DSP opt block of 21 five-bit mux memories.

---
 rtl/ccff_chain_loader_if.sv | 12 +
 rtl/ccff_chain_loader.sv | 192 +++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between the fabric-level source (master) and the
// configuration-chain loader (slave).
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();
  logic [WORD_W-1:0] bs_data;
  logic              bs_valid;
  logic              bs_ready;

  modport master (output bs_data, output bs_valid, input bs_ready);
  modport slave  (input bs_data, input bs_valid, output bs_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words LSB-first onto a tile's ccff chain, CHAIN_LEN shifts per load.
// Define CCFF_CHAIN_LOADER_READBACK_EN to add a CRC-checked recirculating verify pass.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | bs_ready high, chain held, waiting for a bitstream word
// SHIFT  | config_enable high, one word bit onto ccff_head per cycle
// VERIFY | (readback build) chain recirculated tail->head, CRC of tail compared
// DONE   | one-cycle done pulse, then back to IDLE
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 105,
  parameter int WORD_W    = 8
) (
  input  logic               prog_clock,
  input  logic               prog_reset,
  input  logic               start,
  ccff_chain_loader_if.slave bs,
  output logic               config_enable,
  output logic               ccff_head,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int BL_W = $clog2(CHAIN_LEN + 1);
  localparam int NS_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SHIFT  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d, shreg_nxt;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [NS_W-1:0]   nshift_q, nshift_d;
  logic              cfg_en_q, cfg_en_d;
  logic              head_q, head_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, word_last, chain_last;

  assign shreg_nxt  = shreg_q >> 1;
  assign accept     = (state_q == S_FETCH) && bs.bs_valid;
  assign word_last  = (nshift_q == NS_W'(1));
  assign chain_last = (bits_left_q == BL_W'(1));

  // State and registered outputs
  always_ff @(posedge prog_clock) begin
    if (prog_reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      nshift_q    <= '0;
      cfg_en_q    <= 1'b0;
      head_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      nshift_q    <= nshift_d;
      cfg_en_q    <= cfg_en_d;
      head_q      <= head_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (accept) state_d = S_SHIFT;
      S_SHIFT: begin
        if (word_last) begin
          if (chain_last) begin
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
            state_d = S_VERIFY;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_FETCH;
          end
        end
      end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
      S_VERIFY: if (chain_last) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state so they register in step with it.
  always_comb begin
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    nshift_d    = nshift_q;
    head_d      = 1'b0;
    ready_d     = (state_d == S_FETCH);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    cfg_en_d    = (state_d == S_SHIFT) || (state_d == S_VERIFY);
    case (state_q)
      S_IDLE: begin
        if (start) bits_left_d = BL_W'(CHAIN_LEN);
      end
      S_FETCH: begin
        if (accept) begin
          shreg_d = bs.bs_data;
          head_d  = bs.bs_data[0];
          if (32'(bits_left_q) >= WORD_W) nshift_d = NS_W'(WORD_W);
          else                            nshift_d = NS_W'(bits_left_q);
        end
      end
      S_SHIFT: begin
        shreg_d     = shreg_nxt;
        bits_left_d = bits_left_q - 1'b1;
        nshift_d    = nshift_q - 1'b1;
        if (state_d == S_SHIFT) head_d = shreg_nxt[0];
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        // bits_left doubles as the recirculation down-counter
        if (word_last && chain_last) bits_left_d = BL_W'(CHAIN_LEN);
`endif
      end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
      S_VERIFY: bits_left_d = bits_left_q - 1'b1;
`endif
      default: ;
    endcase
  end

  assign config_enable = cfg_en_q;
  assign bs.bs_ready   = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic [7:0] crc_tx_q, crc_rx_q;
  logic       error_q;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  always_ff @(posedge prog_clock) begin
    if (prog_reset) begin
      crc_tx_q <= 8'h00;
      crc_rx_q <= 8'h00;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            crc_tx_q <= 8'h00;
            crc_rx_q <= 8'h00;
            error_q  <= 1'b0;
          end
        end
        S_SHIFT:  crc_tx_q <= crc8_step(crc_tx_q, head_q);
        S_VERIFY: begin
          crc_rx_q <= crc8_step(crc_rx_q, ccff_tail);
          if (chain_last && (crc8_step(crc_rx_q, ccff_tail) != crc_tx_q)) error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Recirculation must be combinational so CHAIN_LEN shifts restore the chain exactly.
  assign ccff_head = (state_q == S_VERIFY) ? ccff_tail : head_q;
  assign error     = error_q;
`else
  logic tail_unused;
  assign tail_unused = ccff_tail;
  assign ccff_head   = head_q;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: randomized loads against a word-to-chain reference model.
module tb_ccff_chain_loader;
  localparam int N  = 105;
  localparam int W  = 8;
  localparam int NW = (N + W - 1) / W;
  localparam int N2 = 16;
  localparam int W2 = 8;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_drv, start_noise, start;
  logic cfg_en, head, tail, busy, done, err;
  logic s_start, s_cfg_en, s_head, s_tail, s_busy, s_done, s_err;
  logic noise_en, flip_en, flip;

  ccff_chain_loader_if #(.WORD_W(W))  bs_if ();
  ccff_chain_loader_if #(.WORD_W(W2)) s_if ();

  assign start = start_drv | start_noise;

  ccff_chain_loader #(.CHAIN_LEN(N), .WORD_W(W)) dut (
    .prog_clock(clk), .prog_reset(rst), .start(start), .bs(bs_if),
    .config_enable(cfg_en), .ccff_head(head), .ccff_tail(tail),
    .busy(busy), .done(done), .error(err));

  ccff_chain_loader #(.CHAIN_LEN(N2), .WORD_W(W2)) dut_s (
    .prog_clock(clk), .prog_reset(rst), .start(s_start), .bs(s_if),
    .config_enable(s_cfg_en), .ccff_head(s_head), .ccff_tail(s_tail),
    .busy(s_busy), .done(s_done), .error(s_err));

  // Chain models: shift toward the tail whenever config_enable is high
  logic [N-1:0]  chain;
  logic [N2-1:0] s_chain;
  assign tail   = chain[N-1] ^ flip;
  assign s_tail = s_chain[N2-1];
  always @(posedge clk) begin
    if (rst) begin
      chain   <= '0;
      s_chain <= '0;
    end else begin
      if (cfg_en)   chain   <= {chain[N-2:0], head};
      if (s_cfg_en) s_chain <= {s_chain[N2-2:0], s_head};
    end
  end

  typedef struct {
    int           nwords;
    int           nready;
    int           lat;
    logic [N-1:0] chain;
    bit           chk_chain;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  logic exp_bits[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops expected bits on every load shift, and a load record on done
  int cyc = 0, t0 = 0, en_cnt = 0, rdy_cnt = 0, wd_cnt = 0;
  bit busy_p = 0, done_p = 0;
  always @(negedge clk) begin
    exp_t e;
    logic b;
    cyc++;
    if (rst) begin
      en_cnt = 0; rdy_cnt = 0; wd_cnt = 0; busy_p = 0; done_p = 0;
    end else begin
      if (busy && !busy_p) begin
        t0 = cyc; en_cnt = 0; rdy_cnt = 0; wd_cnt = 0;
        check("error_clear_on_start", err, 0);
      end
      if (bs_if.bs_ready) begin
        rdy_cnt++;
        check("hold_in_fetch", cfg_en, 0);
        if (bs_if.bs_valid) wd_cnt++;
      end
      if (cfg_en) begin
        if (en_cnt < N) begin
          if (exp_bits.size() == 0) check("unexpected_shift", 1, 0);
          else begin
            b = exp_bits.pop_front();
            check("head_bit", head, b);
          end
        end
        en_cnt++;
      end
      if (done) begin
        check("done_single_cycle", done_p, 0);
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("enable_cycles", en_cnt, N * (1 + RB));
          check("words_consumed", wd_cnt, e.nwords);
          check("ready_cycles", rdy_cnt, e.nready);
          check("latency", cyc - t0 + 1, e.lat);
          check("bits_left_over", exp_bits.size(), 0);
          check("error_at_done", err, e.err);
          if (e.chk_chain) check("chain_contents", chain, e.chain);
        end
      end
      busy_p = busy;
      done_p = done;
    end
  end

  always @(negedge clk) start_noise = noise_en && busy && !done && ($urandom_range(0, 7) == 0);

  always @(negedge clk) begin
    #1;
    flip = flip_en && (en_cnt == N + 10);
  end

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bs_if.bs_ready && t < 300);
    if (!bs_if.bs_ready) check(name, 0, 1);
  endtask

  task automatic run_load(input int pat, input int stall_word, input int stall_len, input bit flip_it);
    logic [W-1:0] w[$];
    logic [W-1:0] wd;
    logic [N-1:0] cv;
    exp_t e;
    int t;
    for (int k = 0; k < NW; k++) w.push_back((pat < 0) ? W'($urandom) : W'(pat));
    cv = '0;
    for (int i = 0; i < N; i++) begin
      wd = w[i / W];
      cv[N-1-i] = wd[i % W];
      exp_bits.push_back(wd[i % W]);
    end
    e.nwords    = NW;
    e.nready    = NW + stall_len;
    e.lat       = NW + N + 1 + stall_len + RB * N;
    e.chain     = cv;
    e.chk_chain = !flip_it;
    e.err       = flip_it;
    exp_q.push_back(e);
    flip_en = flip_it;

    @(posedge clk); #1 start_drv = 1'b1;
    @(posedge clk); #1 start_drv = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (k == stall_word && stall_len > 0) begin
        bs_if.bs_valid = 1'b0;
        wait_ready("stall_ready_timeout");
        repeat (stall_len) @(posedge clk);
        #1;
      end
      bs_if.bs_data  = w[k];
      bs_if.bs_valid = 1'b1;
      wait_ready("word_ready_timeout");
      @(posedge clk); #1;
    end
    bs_if.bs_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", exp_q.size(), 0);
    flip_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_test();
    logic [W-1:0] wd;
    int t;
    wd = W'($urandom);
    for (int i = 0; i < N; i++) exp_bits.push_back(wd[i % W]);
    @(posedge clk); #1 start_drv = 1'b1;
    @(posedge clk); #1 start_drv = 1'b0;
    bs_if.bs_data  = wd;
    bs_if.bs_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (en_cnt < 50 && t < 300);
    check("reach_bit_50", en_cnt, 50);
    rst = 1'b1;
    exp_bits.delete();
    @(negedge clk); #1;
    check("abort_cfg_en", cfg_en, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", bs_if.bs_ready, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    bs_if.bs_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic small_test();
    logic [W2-1:0] sw[2];
    logic [W2-1:0] wd;
    logic [N2-1:0] exp_seq, exp_ch, seq;
    int nb, nacc, t0s, lat;
    bit seen;
    sw[0] = 8'hFF;
    sw[1] = 8'h00;
    exp_seq = '0; exp_ch = '0; seq = '0;
    for (int i = 0; i < N2; i++) begin
      wd = sw[i / W2];
      exp_seq[i]      = wd[i % W2];
      exp_ch[N2-1-i]  = wd[i % W2];
    end
    nb = 0; nacc = 0; t0s = 0; lat = 0; seen = 0;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    s_if.bs_data  = sw[0];
    s_if.bs_valid = 1'b1;
    for (int c = 1; c <= 80 && !seen; c++) begin
      @(negedge clk);
      if (nacc == 1) s_if.bs_data = sw[1];
      if (nacc == 2) s_if.bs_valid = 1'b0;
      if (s_if.bs_ready && s_if.bs_valid) nacc++;
      if (s_busy && t0s == 0) t0s = c;
      if (s_cfg_en) begin
        if (nb < N2) seq[nb] = s_head;
        nb++;
      end
      if (s_done) begin
        seen = 1;
        lat  = c - t0s + 1;
      end
    end
    check("small_done_seen", seen, 1);
    check("small_head_sequence", seq, exp_seq);
    check("small_enable_cycles", nb, N2 * (1 + RB));
    check("small_words", nacc, 2);
    check("small_latency", lat, 2 + N2 + 1 + RB * N2);
    check("small_chain", s_chain, exp_ch);
    check("small_error", s_err, 0);
  endtask

  initial begin
    rst = 1'b1; start_drv = 1'b0; s_start = 1'b0;
    noise_en = 1'b0; flip_en = 1'b0; flip = 1'b0;
    bs_if.bs_data = '0; bs_if.bs_valid = 1'b0;
    s_if.bs_data  = '0; s_if.bs_valid  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cfg_en", cfg_en, 0);
    check("reset_head", head, 0);
    check("reset_ready", bs_if.bs_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", err, 0);
    #1 rst = 1'b0;

    run_load(8'hA5, -1, 0, 1'b0);
    run_load(-1, 5, 10, 1'b0);
    noise_en = 1'b1;
    run_load(-1, -1, 0, 1'b0);
    run_load(-1, 3, 4, 1'b0);
    noise_en = 1'b0;
    reset_test();
    run_load(-1, -1, 0, 1'b0);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    run_load(-1, -1, 0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("error_sticky", err, 1);
    run_load(-1, -1, 0, 1'b0);
`endif
    small_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
